// File: rtl/output_readout_streamer.sv
// output_readout_streamer: drains the DIM*DIM-word result memory onto a
// valid/ready stream. It hides the memory's one-cycle registered read
// latency with a two-entry output FIFO and a credit check on read issue.
// Optional build macro: TRANSPOSE_READOUT_EN selects column-major readout.
module output_readout_streamer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int DIM       = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [3:0]        out_idx
);

  localparam int N_WORDS = DIM * DIM;
  localparam int SEQ_W   = $clog2(N_WORDS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [SEQ_W-1:0]  seq;
  logic [ADDR_W-1:0] last_addr;
  logic              vld_p1;
  logic [3:0]        idx_p1;
  logic              last_p1;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_idx;
  logic              s_last;
  logic              s_valid;
  logic [1:0]        fifo_cnt;
  logic              pop;
  logic              issue;
  logic              last_hs;

  // Memory address of the seq-th word of the job.
  function automatic logic [ADDR_W-1:0] seq_addr(input logic [SEQ_W-1:0] s);
    int v;
`ifdef TRANSPOSE_READOUT_EN
    v = BASE_ADDR + (int'(s) % DIM) * DIM + int'(s) / DIM;
`else
    v = BASE_ADDR + int'(s);
`endif
    return v[ADDR_W-1:0];
  endfunction

  assign fifo_cnt = {1'b0, out_valid} + {1'b0, s_valid};
  assign pop      = out_valid && out_ready;
  assign last_hs  = pop && out_last && (state == S_DRAIN);
  assign busy     = (state != S_IDLE);
  assign last_p1  = (idx_p1 == 4'(N_WORDS - 1));

  // A read may only be issued if the word it returns is guaranteed a FIFO slot:
  // occupancy after this cycle's pop plus the read already in flight.
  assign issue = (state == S_RUN) &&
                 ((int'(fifo_cnt) + int'(vld_p1) - int'(pop)) < 2);

  // Address is driven straight from the issue counter on issue cycles, else held.
  assign rd_addr = issue ? seq_addr(seq) : last_addr;

  // Job sequencing: issue counter, state and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      seq   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_hs;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            seq   <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            seq <= seq + SEQ_W'(1);
            if (seq == SEQ_W'(N_WORDS - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_hs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: track the read in flight and hold the last issued address.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      last_addr <= ADDR_W'(BASE_ADDR);
    end else begin
      vld_p1 <= issue;
      if (issue) last_addr <= seq_addr(seq);
    end
  end

  // Index tag travelling with the in-flight read.
  always_ff @(posedge clk) begin
    if (issue) idx_p1 <= seq[3:0];
  end

  // Stage p1 -> output: two-entry FIFO; head entry drives the stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      s_valid   <= 1'b0;
    end else begin
      if (vld_p1 && pop) begin
        if (s_valid) begin
          out_data <= s_data;
          out_idx  <= s_idx;
          out_last <= s_last;
          s_data   <= rd_data;
          s_idx    <= idx_p1;
          s_last   <= last_p1;
        end else begin
          out_data <= rd_data;
          out_idx  <= idx_p1;
          out_last <= last_p1;
        end
      end else if (pop) begin
        out_valid <= s_valid;
        s_valid   <= 1'b0;
        if (s_valid) begin
          out_data <= s_data;
          out_idx  <= s_idx;
          out_last <= s_last;
        end
      end else if (vld_p1) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= rd_data;
          out_idx   <= idx_p1;
          out_last  <= last_p1;
        end else begin
          s_valid <= 1'b1;
          s_data  <= rd_data;
          s_idx   <= idx_p1;
          s_last  <= last_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_readout_streamer.sv
// Bench for output_readout_streamer: memory model, randomized sink readiness,
// scoreboard fed at job start and drained by an independent output monitor.
module tb_output_readout_streamer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DIM    = 4;
  localparam int BASE   = 0;
  localparam int NW     = DIM * DIM;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic [3:0]        out_idx;

  output_readout_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM(DIM), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // Result memory with one-cycle registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  typedef struct {
    logic [DATA_W-1:0] data;
    int                idx;
    bit                last;
    int                cyc;
  } exp_t;
  exp_t q[$];

  bit                mdl_busy = 1'b0;
  int                done_due = -1;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [3:0]        prev_idx;
  logic              prev_last;

  // Memory address holding the k-th streamed word.
  function automatic int exp_addr(int k);
`ifdef TRANSPOSE_READOUT_EN
    return BASE + (k % DIM) * DIM + k / DIM;
`else
    return BASE + k;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    bit exp_done;
    exp_t e;
    if (rst) begin
      q.delete();
      mdl_busy   = 1'b0;
      done_due   = -1;
      prev_stall = 1'b0;
    end else begin
      exp_done = (cyc == done_due);
      if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
      if (exp_done) mdl_busy = 1'b0;
      chk("busy", 32'(busy), 32'(mdl_busy));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_idx", 32'(out_idx), 32'(prev_idx));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (q.size() == 0) begin
          chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("idx", 32'(out_idx), 32'(e.idx));
          chk("last", 32'(out_last), 32'(e.last));
          if (e.cyc >= 0) chk("hs_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (out_last) done_due = cyc + 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
      if (start && !mdl_busy) begin
        mdl_busy = 1'b1;
        for (int k = 0; k < NW; k++) begin
          e.data = mem[exp_addr(k)];
          e.idx  = k;
          e.last = (k == NW - 1);
          e.cyc  = (ready_mode == 0) ? cyc + 3 + k : -1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while ((mdl_busy || q.size() != 0) && n < bound) begin
      step();
      n++;
    end
    chk("job_timeout", 32'(n >= bound), 32'd0);
    step();
    step();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'(BASE));
  endtask

  initial begin
    int t0;
    int hs0;
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(16'hA000 + i);

    repeat (3) step();
    rst = 1'b0;
    chk_reset_outputs("rst_init");

    // Full-rate job: timing enforced through the scoreboard cycle field.
    ready_mode = 0;
    step();
    pulse_start();
    wait_idle(200);

    // Random backpressure on the same contents.
    ready_mode = 1;
    pulse_start();
    wait_idle(400);

    // Sink held off: two reads absorbed, head word held, address held.
    ready_mode = 2;
    step();
    pulse_start();
    repeat (20) step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'(mem[exp_addr(0)]));
    chk("stall_addr", 32'(rd_addr), 32'(exp_addr(1)));
    ready_mode = 0;
    wait_idle(200);

    // Start while busy is dropped; start on the done cycle launches a job.
    ready_mode = 0;
    step();
    hs0 = hs_count;
    t0 = cyc;
    pulse_start();
    while (cyc < t0 + 5) step();
    pulse_start();
    while (cyc < t0 + 19) step();
    pulse_start();
    wait_idle(200);
    chk("two_jobs_words", 32'(hs_count - hs0), 32'(2 * NW));

    // Reset in the middle of a job, then a clean job.
    ready_mode = 0;
    hs0 = hs_count;
    pulse_start();
    n = 0;
    while (hs_count < hs0 + 7 && n < 100) begin
      step();
      n++;
    end
    chk("mid_reset_reach", 32'(hs_count >= hs0 + 7), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_mid");
    step();
    pulse_start();
    wait_idle(200);

    // Random contents under random backpressure, back to back.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
      ready_mode = 1;
      pulse_start();
      wait_idle(400);
    end

    // Identity contents show the readout order directly.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
    ready_mode = 0;
    pulse_start();
    wait_idle(200);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
